// File: rtl/btn_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_reset_pkg
// Description : Shared definitions for the button-driven bootloader reset
//               controller: FSM state type and encodings, default timing
//               constants, and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_reset_pkg;

   // Default timing, all in clk48 cycles
   localparam int unsigned c_debounce_cyc_def  = 480000;    // 10 ms
   localparam int unsigned c_long_cyc_def      = 96000000;  // 2 s
   localparam int unsigned c_rst_pulse_cyc_def = 16;

   // Controller FSM state type and encodings
   typedef logic [1:0] state_t;
   localparam state_t c_st_idle    = 2'd0;
   localparam state_t c_st_hold    = 2'd1;
   localparam state_t c_st_pulse   = 2'd2;
   localparam state_t c_st_lockout = 2'd3;

   // Bits needed to hold 0..max_cnt, never less than one bit
   function automatic int unsigned cnt_width(input int unsigned max_cnt);
      int unsigned w;
      w = $clog2(max_cnt + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer followed by a debouncer for an
//               active-low raw button. The debounced level only changes
//               once the synchronized input has disagreed with it for
//               DEBOUNCE_CYC consecutive cycles.
// Ports       : clk48  - 48 MHz clock
//               rst_n  - asynchronous active-low reset
//               raw_n  - raw asynchronous button (0 = pressed)
//               level  - registered debounced level (1 = pressed)
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
   import btn_reset_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = c_debounce_cyc_def
) (
   input  logic clk48,
   input  logic rst_n,
   input  logic raw_n,
   output logic level
);

   localparam int unsigned c_cnt_w = cnt_width(DEBOUNCE_CYC - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYC - 1);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_level;
   logic [c_cnt_w-1:0] r_cnt;
   logic               w_pressed_sync;

   assign w_pressed_sync = ~r_sync2;

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         // Synchronizer idles at "released" so reset never looks like a press
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= raw_n;
         r_sync2 <= r_sync1;
         if (w_pressed_sync == r_level) begin
            // Input agrees with current level: any bounce restarts the count
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_max) begin
            r_level <= w_pressed_sync;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/btn_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btn_reset_ctrl
// Description : Long-press bootloader reset controller. A debounced press
//               held for LONG_CYC cycles issues one RST_PULSE_CYC-wide
//               active-low pulse on boot_rst_n; the button must then be
//               released before another press can be timed.
// Ports       : clk48       - 48 MHz clock
//               rst_n       - asynchronous active-low reset
//               usr_btn     - raw button, active-low
//               boot_rst_n  - registered active-low bootloader reset
//               btn_pressed - registered debounced level (1 = pressed)
//               hold_active - registered, high while a press is timed
//               short_press - (BTN_RESET_SHORT_EVT_EN only) one-cycle pulse
//                             when a press ends before the long threshold
// Macro       : BTN_RESET_SHORT_EVT_EN - enables the short_press output
// Revision    : 1.0 - initial release
// ============================================================================
module btn_reset_ctrl
   import btn_reset_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC  = c_debounce_cyc_def,
   parameter int unsigned LONG_CYC      = c_long_cyc_def,
   parameter int unsigned RST_PULSE_CYC = c_rst_pulse_cyc_def
) (
   input  logic clk48,
   input  logic rst_n,
   input  logic usr_btn,
   output logic boot_rst_n,
   output logic btn_pressed,
   output logic hold_active
`ifdef BTN_RESET_SHORT_EVT_EN
   ,
   output logic short_press
`endif
);

   localparam int unsigned c_hold_w  = cnt_width(LONG_CYC - 1);
   localparam int unsigned c_pulse_w = cnt_width(RST_PULSE_CYC - 1);
   localparam logic [c_hold_w-1:0]  c_hold_max  = c_hold_w'(LONG_CYC - 1);
   localparam logic [c_pulse_w-1:0] c_pulse_max = c_pulse_w'(RST_PULSE_CYC - 1);

   logic                 w_level;
   logic                 w_press_edge;
   logic                 r_level_d;
   state_t               r_state;
   logic [c_hold_w-1:0]  r_hold_cnt;
   logic [c_pulse_w-1:0] r_pulse_cnt;
   logic                 r_boot_rst_n;
   logic                 r_hold_active;
`ifdef BTN_RESET_SHORT_EVT_EN
   logic                 r_short_press;
`endif

   btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .clk48 (clk48),
      .rst_n (rst_n),
      .raw_n (usr_btn),
      .level (w_level)
   );

   assign w_press_edge = w_level & ~r_level_d;

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_level_d     <= 1'b0;
         r_state       <= c_st_idle;
         r_hold_cnt    <= '0;
         r_pulse_cnt   <= '0;
         r_boot_rst_n  <= 1'b1;
         r_hold_active <= 1'b0;
`ifdef BTN_RESET_SHORT_EVT_EN
         r_short_press <= 1'b0;
`endif
      end else begin
         r_level_d <= w_level;
`ifdef BTN_RESET_SHORT_EVT_EN
         r_short_press <= 1'b0;
`endif
         case (r_state)
            c_st_idle: begin
               if (w_press_edge) begin
                  r_hold_cnt    <= '0;
                  r_hold_active <= 1'b1;
                  r_state       <= c_st_hold;
               end
            end

            c_st_hold: begin
               // Reaching the threshold was already qualified by the press
               // still being held, so it takes priority over a release seen
               // on the following cycle.
               if (r_hold_cnt == c_hold_max) begin
                  r_pulse_cnt   <= '0;
                  r_boot_rst_n  <= 1'b0;
                  r_hold_active <= 1'b0;
                  r_state       <= c_st_pulse;
               end else if (!w_level) begin
                  r_hold_active <= 1'b0;
                  r_state       <= c_st_idle;
`ifdef BTN_RESET_SHORT_EVT_EN
                  r_short_press <= 1'b1;
`endif
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end

            c_st_pulse: begin
               // Pulse runs to completion whatever the button does
               if (r_pulse_cnt == c_pulse_max) begin
                  r_boot_rst_n <= 1'b1;
                  r_state      <= c_st_lockout;
               end else begin
                  r_pulse_cnt <= r_pulse_cnt + 1'b1;
               end
            end

            c_st_lockout: begin
               if (!w_level) begin
                  r_state <= c_st_idle;
               end
            end

            default: begin
               r_boot_rst_n  <= 1'b1;
               r_hold_active <= 1'b0;
               r_state       <= c_st_idle;
            end
         endcase
      end
   end

   assign boot_rst_n  = r_boot_rst_n;
   assign btn_pressed = w_level;
   assign hold_active = r_hold_active;
`ifdef BTN_RESET_SHORT_EVT_EN
   assign short_press = r_short_press;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btn_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_reset_ctrl
// Description : Directed self-checking bench for btn_reset_ctrl with
//               DEBOUNCE_CYC=4, LONG_CYC=20, RST_PULSE_CYC=3.
// Macro       : BTN_RESET_SHORT_EVT_EN - also checks short_press
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_reset_ctrl;

   logic clk48;
   logic rst_n;
   logic usr_btn;
   logic boot_rst_n;
   logic btn_pressed;
   logic hold_active;
`ifdef BTN_RESET_SHORT_EVT_EN
   logic short_press;
`endif

   int checks = 0;
   int errors = 0;

   // Per-scenario observations
   int cyc;
   int rise_at;
   int n_hold;
   int n_boot_low;
   int n_pulses;
   int n_short;
   logic prev_boot;
   logic prev_press;

   btn_reset_ctrl #(
      .DEBOUNCE_CYC  (4),
      .LONG_CYC      (20),
      .RST_PULSE_CYC (3)
   ) dut (
      .clk48       (clk48),
      .rst_n       (rst_n),
      .usr_btn     (usr_btn),
      .boot_rst_n  (boot_rst_n),
      .btn_pressed (btn_pressed),
      .hold_active (hold_active)
`ifdef BTN_RESET_SHORT_EVT_EN
      ,
      .short_press (short_press)
`endif
   );

   initial clk48 = 1'b0;
   always #5 clk48 = ~clk48;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      cyc        = 0;
      rise_at    = -1;
      n_hold     = 0;
      n_boot_low = 0;
      n_pulses   = 0;
      n_short    = 0;
      prev_boot  = boot_rst_n;
      prev_press = btn_pressed;
   endtask

   // One clock, sampled 1 ns after the rising edge
   task automatic tick();
      @(posedge clk48);
      #1;
      cyc++;
      if (!boot_rst_n) n_boot_low++;
      if (prev_boot && !boot_rst_n) n_pulses++;
      if (hold_active) n_hold++;
      if (btn_pressed && !prev_press && rise_at < 0) rise_at = cyc;
`ifdef BTN_RESET_SHORT_EVT_EN
      if (short_press) n_short++;
`endif
      prev_boot  = boot_rst_n;
      prev_press = btn_pressed;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n   = 1'b0;
      usr_btn = 1'b1;
      @(posedge clk48);
      #1;

      // Reset state, including a press applied while reset is held
      usr_btn = 1'b0;
      ticks(4);
      chk("rst_boot", boot_rst_n, 1);
      chk("rst_pressed", btn_pressed, 0);
      chk("rst_hold", hold_active, 0);
`ifdef BTN_RESET_SHORT_EVT_EN
      chk("rst_short", short_press, 0);
`endif
      usr_btn = 1'b1;
      ticks(2);
      rst_n = 1'b1;
      ticks(8);

      // Bounce: toggling every 2 cycles never qualifies
      clr();
      for (int i = 0; i < 20; i++) begin
         usr_btn = ((i / 2) % 2) != 0;
         tick();
      end
      usr_btn = 1'b1;
      ticks(10);
      chk("bounce_rise", rise_at, -1);
      chk("bounce_boot_low", n_boot_low, 0);
      chk("bounce_hold", n_hold, 0);

      // Long press held 40 cycles
      clr();
      usr_btn = 1'b0;
      ticks(40);
      chk("long_rise_at", rise_at, 6);
      chk("long_hold_cycles", n_hold, 20);
      chk("long_boot_low", n_boot_low, 3);
      chk("long_pulses", n_pulses, 1);
      chk("long_lockout_boot", boot_rst_n, 1);
      chk("long_lockout_hold", hold_active, 0);
      usr_btn = 1'b1;
      ticks(12);
      chk("long_released", btn_pressed, 0);
      chk("long_no_second", n_pulses, 1);
`ifdef BTN_RESET_SHORT_EVT_EN
      chk("long_short", n_short, 0);
`endif

      // Short press of 12 cycles
      clr();
      usr_btn = 1'b0;
      ticks(12);
      usr_btn = 1'b1;
      ticks(14);
      chk("short_pulses", n_pulses, 0);
      chk("short_hold", n_hold, 12);
`ifdef BTN_RESET_SHORT_EVT_EN
      chk("short_evt", n_short, 1);
`endif

      // Boundary: 19 cycles -> no pulse
      clr();
      usr_btn = 1'b0;
      ticks(19);
      usr_btn = 1'b1;
      ticks(14);
      chk("b19_pulses", n_pulses, 0);
      chk("b19_hold", n_hold, 19);
`ifdef BTN_RESET_SHORT_EVT_EN
      chk("b19_short", n_short, 1);
`endif

      // Boundary: 20 cycles -> exactly one pulse
      clr();
      usr_btn = 1'b0;
      ticks(20);
      usr_btn = 1'b1;
      ticks(30);
      chk("b20_pulses", n_pulses, 1);
      chk("b20_boot_low", n_boot_low, 3);
      chk("b20_hold", n_hold, 20);
`ifdef BTN_RESET_SHORT_EVT_EN
      chk("b20_short", n_short, 0);
`endif

      // Reset asserted during the 2nd low cycle of the pulse
      clr();
      usr_btn = 1'b0;
      for (int k = 0; k < 60 && n_boot_low < 2; k++) tick();
      chk("mid_reach", n_boot_low, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_async_boot", boot_rst_n, 1);
      chk("mid_async_pressed", btn_pressed, 0);
      usr_btn = 1'b1;
      ticks(3);
      rst_n = 1'b1;
      clr();
      ticks(10);
      chk("mid_idle_hold", n_hold, 0);
      chk("mid_idle_boot", n_boot_low, 0);

      // Held through the release of reset
      rst_n   = 1'b0;
      usr_btn = 1'b0;
      ticks(3);
      chk("thru_rst_pressed", btn_pressed, 0);
      clr();
      rst_n = 1'b1;
      ticks(40);
      chk("thru_rise_at", rise_at, 6);
      chk("thru_hold", n_hold, 20);
      chk("thru_boot_low", n_boot_low, 3);
      chk("thru_pulses", n_pulses, 1);
      usr_btn = 1'b1;
      ticks(12);
      chk("thru_released", btn_pressed, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
